// File: rtl/gpio_bank_irq.sv
// GPIO bank: per-pin direction, registered outputs, synchronised and
// debounced inputs, per-pin edge/level interrupts with sticky W1C status
// and one registered global interrupt line.
module gpio_bank_irq #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Enable,
    inout  wire  [WIDTH-1:0]      PIN_DATA,
    input  logic [WIDTH-1:0]      Function,
    input  logic [WIDTH-1:0]      Data_out,
    input  logic [WIDTH-1:0]      Int_Enable,
    input  logic [2*WIDTH-1:0]    Int_Mode,
    input  logic [DEB_BITS-1:0]   Deb_Limit,
    input  logic [WIDTH-1:0]      Irq_Clear,
    output logic [WIDTH-1:0]      Data_in,
    output logic [WIDTH-1:0]      Pin_out,
    output logic [WIDTH-1:0]      Irq_Status,
    output logic                  IRQ
);

    localparam logic [1:0] MODE_RISE  = 2'b00;
    localparam logic [1:0] MODE_FALL  = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;
    localparam logic [1:0] MODE_LEVEL = 2'b11;

    logic [WIDTH-1:0]    sync_p [SYNC_STAGES];
    logic [WIDTH-1:0]    sync_val;
    logic [DEB_BITS-1:0] cnt      [WIDTH];
    logic [DEB_BITS-1:0] cnt_nxt  [WIDTH];
    logic [WIDTH-1:0]    din_nxt;
    logic [WIDTH-1:0]    prev;
    logic [WIDTH-1:0]    rise;
    logic [WIDTH-1:0]    fall;
    logic [WIDTH-1:0]    evt;
    logic [WIDTH-1:0]    set_bits;
    logic [WIDTH-1:0]    drive_en;

    // Pads are driven only for output pins while the bank is enabled.
    assign drive_en = Function & {WIDTH{~Enable}};

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign PIN_DATA[g] = drive_en[g] ? Pin_out[g] : 1'bz;
    end

    // Output data register: loads while enabled, holds while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Pin_out <= '0;
        end else if (!Enable) begin
            Pin_out <= Data_out;
        end
    end

    // Input synchroniser; pads are sampled regardless of direction so
    // output pins read back their driven level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p[s] <= '0;
            end
        end else begin
            sync_p[0] <= PIN_DATA;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
        end
    end

    assign sync_val = sync_p[SYNC_STAGES-1];

    // Debounce next state: a mismatch must survive Deb_Limit+1 cycles;
    // a counter above a lowered limit accepts on the next mismatch.
    always_comb begin
        din_nxt = Data_in;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync_val[i] != Data_in[i]) begin
                if (cnt[i] < Deb_Limit) begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end else begin
                    din_nxt[i] = sync_val[i];
                end
            end
        end
    end

    // Debounce state: counters, accepted level and the edge-history copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            Data_in <= '0;
            prev    <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            Data_in <= din_nxt;
            prev    <= Data_in;
        end
    end

    assign rise = Data_in & ~prev;
    assign fall = ~Data_in & prev;

    // Per-pin event select; events come only from Data_in history, so a
    // mode change alone cannot raise an edge event.
    always_comb begin
        evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (Int_Mode[2*i +: 2])
                MODE_RISE:  evt[i] = rise[i];
                MODE_FALL:  evt[i] = fall[i];
                MODE_BOTH:  evt[i] = rise[i] | fall[i];
                MODE_LEVEL: evt[i] = Data_in[i];
                default:    evt[i] = 1'b0;
            endcase
        end
    end

    assign set_bits = evt & Int_Enable & {WIDTH{~Enable}};

    // Sticky status with write-1-to-clear; a new set beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Irq_Status <= '0;
        end else begin
            Irq_Status <= set_bits | (Irq_Status & ~Irq_Clear);
        end
    end

    // Global interrupt, one clock behind the status bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IRQ <= 1'b0;
        end else begin
            IRQ <= |Irq_Status;
        end
    end

endmodule

// File: tb/tb_gpio_bank_irq.sv
// Bench for gpio_bank_irq: directed scenarios with literal expectations,
// then randomised traffic, all checked against a behavioural model.
module tb_gpio_bank_irq;

    localparam int W  = 16;
    localparam int SS = 2;
    localparam int DB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            en_n;
    logic [W-1:0]    func;
    logic [W-1:0]    dout;
    logic [W-1:0]    ie;
    logic [2*W-1:0]  mode;
    logic [DB-1:0]   lim;
    logic [W-1:0]    clr;
    logic [W-1:0]    tbv;
    logic [W-1:0]    tb_oe;
    wire  [W-1:0]    pad;
    logic [W-1:0]    din;
    logic [W-1:0]    pout;
    logic [W-1:0]    stat;
    logic            irq;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    gpio_bank_irq #(.WIDTH(W), .SYNC_STAGES(SS), .DEB_BITS(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .Enable     (en_n),
        .PIN_DATA   (pad),
        .Function   (func),
        .Data_out   (dout),
        .Int_Enable (ie),
        .Int_Mode   (mode),
        .Deb_Limit  (lim),
        .Irq_Clear  (clr),
        .Data_in    (din),
        .Pin_out    (pout),
        .Irq_Status (stat),
        .IRQ        (irq)
    );

    // External world drives every pad the bank is not driving.
    assign tb_oe = ~(func & {W{~en_n}});
    for (genvar g = 0; g < W; g++) begin : g_ext
        assign pad[g] = tb_oe[g] ? tbv[g] : 1'bz;
    end

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_pout, m_din, m_prev, m_stat;
    logic         m_irq;
    logic [W-1:0] m_hist [SS];
    int           m_run  [W];
    logic [W-1:0] m_pad;

    assign m_pad = (func & {W{~en_n}} & m_pout) | (tb_oe & tbv);

    always @(posedge clk or posedge reset) begin
        logic [W-1:0] pad_now, seen, n_din, ev;
        if (reset) begin
            m_pout = '0; m_din = '0; m_prev = '0; m_stat = '0; m_irq = 1'b0;
            for (int k = 0; k < SS; k++) m_hist[k] = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            pad_now = m_pad;
            seen    = m_hist[SS-1];
            for (int i = 0; i < W; i++) begin
                case (mode[2*i +: 2])
                    2'b00: ev[i] = m_din[i] && !m_prev[i];
                    2'b01: ev[i] = !m_din[i] && m_prev[i];
                    2'b10: ev[i] = m_din[i] != m_prev[i];
                    default: ev[i] = m_din[i];
                endcase
            end
            m_irq  = (m_stat != 0);
            m_stat = (ev & ie & {W{~en_n}}) | (m_stat & ~clr);
            n_din  = m_din;
            for (int i = 0; i < W; i++) begin
                if (seen[i] == m_din[i]) m_run[i] = 0;
                else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] > int'(lim)) begin
                        n_din[i] = seen[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_prev = m_din;
            m_din  = n_din;
            for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pad_now;
            if (!en_n) m_pout = dout;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_din",  32'(din),  32'(m_din));
            chk("cyc_pout", 32'(pout), 32'(m_pout));
            chk("cyc_stat", 32'(stat), 32'(m_stat));
            chk("cyc_irq",  32'(irq),  32'(m_irq));
            chk("cyc_pad",  32'(pad),  32'(m_pad));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; en_n = 1'b1; func = '0; dout = '0; ie = '0;
        mode = '0; lim = '0; clr = '0; tbv = '0;
        step(3);
        reset = 1'b0;
        chk_on = 1'b1;
        chk("init_pout", 32'(pout), 32'h0);
        chk("init_stat", 32'(stat), 32'h0);

        // Reset mid-operation with Pin_out=FFFF and status=0003.
        en_n = 1'b0; dout = 16'hFFFF; func = '0; tbv = 16'h0003;
        ie = 16'h0003; mode = '1; lim = '0;
        step(1);
        chk("a_pout", 32'(pout), 32'hFFFF);
        step(5);
        chk("a_stat", 32'(stat), 32'h0003);
        chk("a_irq",  32'(irq),  32'h1);
        reset = 1'b1;
        #1;
        chk("rst_pout", 32'(pout), 32'h0);
        chk("rst_din",  32'(din),  32'h0);
        chk("rst_stat", 32'(stat), 32'h0);
        chk("rst_irq",  32'(irq),  32'h0);
        dout = '0; tbv = '0; ie = '0; mode = '0;
        step(2);
        reset = 1'b0;
        step(5);
        chk("post_pout", 32'(pout), 32'h0);
        chk("post_din",  32'(din),  32'h0);
        chk("post_stat", 32'(stat), 32'h0);
        chk("post_irq",  32'(irq),  32'h0);

        // Output and readback.
        func = 16'h00FF; dout = 16'h00A5; lim = 4'd2;
        step(1);
        chk("b_pout", 32'(pout), 32'h00A5);
        chk("b_pad",  32'(pad),  32'h00A5);
        step(4);
        chk("b_din_early", 32'(din), 32'h0000);
        step(1);
        chk("b_din", 32'(din), 32'h00A5);
        en_n = 1'b1; dout = 16'h1234;
        #1;
        chk("b_pad_off", 32'(pad), 32'h0000);
        step(2);
        chk("b_pout_hold", 32'(pout), 32'h00A5);

        // Debounce with limit 3 on pin 4.
        en_n = 1'b0; func = '0; dout = '0; lim = 4'd3; tbv = '0;
        step(12);
        tbv[4] = 1'b1;
        step(3);
        tbv[4] = 1'b0;
        step(8);
        chk("c_glitch", 32'(din[4]), 32'h0);
        tbv[4] = 1'b1;
        step(5);
        chk("c_din_5", 32'(din[4]), 32'h0);
        step(1);
        chk("c_din_6", 32'(din[4]), 32'h1);

        // Rising on pin 4, falling on pin 5.
        tbv = '0;
        step(12);
        ie = 16'h0030; mode = '0; mode[11:10] = 2'b01; clr = '1;
        step(1);
        clr = '0;
        tbv[5:4] = 2'b11;
        step(6);
        chk("d_din4",  32'(din[4]),  32'h1);
        chk("d_st4_0", 32'(stat[4]), 32'h0);
        step(1);
        chk("d_st4_1", 32'(stat[4]), 32'h1);
        chk("d_irq_0", 32'(irq),     32'h0);
        step(1);
        chk("d_irq_1", 32'(irq),     32'h1);
        tbv[5:4] = 2'b00;
        step(6);
        chk("d_din5",  32'(din[5]),  32'h0);
        chk("d_st5_0", 32'(stat[5]), 32'h0);
        step(1);
        chk("d_st5_1", 32'(stat[5]), 32'h1);
        clr = 16'h0010;
        step(1);
        clr = '0;
        chk("d_clr4", 32'(stat & 16'h0030), 32'h0020);
        chk("d_irq",  32'(irq), 32'h1);

        // Both-edge on pin 2, level on pin 3.
        ie = 16'h000C; mode = '0; mode[5:4] = 2'b10; mode[7:6] = 2'b11; clr = '1;
        step(1);
        clr = '0;
        tbv[2] = 1'b1;
        step(6);
        chk("e_st2_0", 32'(stat[2]), 32'h0);
        step(1);
        chk("e_st2_r", 32'(stat[2]), 32'h1);
        clr = 16'h0004;
        step(1);
        clr = '0;
        chk("e_st2_c", 32'(stat[2]), 32'h0);
        tbv[2] = 1'b0;
        step(7);
        chk("e_st2_f", 32'(stat[2]), 32'h1);
        tbv[3] = 1'b1;
        step(7);
        chk("e_st3_l", 32'(stat[3]), 32'h1);
        clr = 16'h0008;
        step(1);
        clr = '0;
        chk("e_st3_hi", 32'(stat[3]), 32'h1);
        tbv[3] = 1'b0;
        step(7);
        clr = 16'h0008;
        step(1);
        clr = '0;
        chk("e_st3_clr", 32'(stat[3]), 32'h0);
        step(3);
        chk("e_st3_hold", 32'(stat[3]), 32'h0);

        // Set and clear in the same cycle on pin 6.
        ie = 16'h0040; mode = '0; clr = '1;
        step(1);
        clr = '0;
        tbv[6] = 1'b1;
        step(8);
        chk("f_st6_pre", 32'(stat[6]), 32'h1);
        tbv[6] = 1'b0;
        step(8);
        tbv[6] = 1'b1;
        step(6);
        clr = 16'h0040;
        step(1);
        clr = '0;
        chk("f_st6", 32'(stat[6]), 32'h1);
        chk("f_irq", 32'(irq),     32'h1);
        step(1);
        chk("f_st6_keep", 32'(stat[6]), 32'h1);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(7) == 0) tbv[i] = ~tbv[i];
            dout = W'($urandom);
            clr  = W'($urandom & $urandom & $urandom);
            if ($urandom_range(63) == 0) func = W'($urandom);
            if ($urandom_range(40) == 0) en_n = ~en_n;
            if ($urandom_range(49) == 0) ie = W'($urandom);
            if ($urandom_range(49) == 0) mode = $urandom;
            if ($urandom_range(99) == 0) lim = DB'($urandom_range(6));
            step(1);
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
